// File: rtl/periph_bus_pkg.sv
// Shared constants for the peripheral window: register word offsets and TCON bit positions.
package periph_bus_pkg;

  // Word index of each register, taken from Address[4:2]
  localparam logic [2:0] TH_OFF      = 3'd0;
  localparam logic [2:0] TL_OFF      = 3'd1;
  localparam logic [2:0] TCON_OFF    = 3'd2;
  localparam logic [2:0] LED_OFF     = 3'd3;
  localparam logic [2:0] SWITCH_OFF  = 3'd4;
  localparam logic [2:0] DIGI_OFF    = 3'd5;
  localparam logic [2:0] SYSTICK_OFF = 3'd6;

  localparam int TCON_W  = 3;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  localparam int DIGI_W = 12;

endpackage

// File: rtl/periph_timer.sv
// Interval timer: TL counts up while enabled, reloads from TH on all-ones and latches the IRQ status.
module periph_timer
  import periph_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_th,
  input  logic              i_wr_tl,
  input  logic              i_wr_tcon,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_th,
  output logic [31:0]       o_tl,
  output logic [TCON_W-1:0] o_tcon
);

  logic [31:0]       r_th;
  logic [31:0]       r_tl;
  logic [TCON_W-1:0] r_tcon;
  logic              w_ovf;

  assign w_ovf = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

  // CPU writes take precedence over the timer's own update of the same register,
  // so a TCON write on the overflow edge deliberately drops that interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (i_wr_th)
        r_th <= i_wdata;

      if (i_wr_tl)
        r_tl <= i_wdata;
      else if (w_ovf)
        r_tl <= r_th;
      else if (r_tcon[TCON_EN])
        r_tl <= r_tl + 32'd1;

      if (i_wr_tcon)
        r_tcon <= i_wdata[TCON_W-1:0];
      else if (w_ovf && r_tcon[TCON_IE])
        r_tcon[TCON_IS] <= 1'b1;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;

endmodule

// File: rtl/periph_bus.sv
// Memory-mapped peripheral slave for the single-cycle core: timer, LEDs, 7-segment, switches, systick.
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              IRQ,
  output logic [LED_W-1:0]  leds,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi
);

  logic [2:0]        w_off;
  logic              w_hit;
  logic              w_wr;
  logic [31:0]       w_th;
  logic [31:0]       w_tl;
  logic [TCON_W-1:0] w_tcon;

  logic [LED_W-1:0]  r_led;
  logic [DIGI_W-1:0] r_digi;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;
  logic [31:0]       r_systick;

  // Offset 0x1C is inside the window but has no register behind it
  assign w_off = Address[4:2];
  assign w_hit = (Address[31:5] == BASE_ADDR[31:5]) && (w_off != 3'd7);
  assign w_wr  = MemWrite && w_hit;

  periph_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_wr_th   (w_wr && (w_off == TH_OFF)),
    .i_wr_tl   (w_wr && (w_off == TL_OFF)),
    .i_wr_tcon (w_wr && (w_off == TCON_OFF)),
    .i_wdata   (WriteData),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_digi    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_systick <= '0;
    end else begin
      if (w_wr && (w_off == LED_OFF))
        r_led <= WriteData[LED_W-1:0];
      if (w_wr && (w_off == DIGI_OFF))
        r_digi <= WriteData[DIGI_W-1:0];
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      r_systick <= r_systick + 32'd1;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && w_hit) begin
      case (w_off)
        TH_OFF:      ReadData = w_th;
        TL_OFF:      ReadData = w_tl;
        TCON_OFF:    ReadData = {{(32-TCON_W){1'b0}}, w_tcon};
        LED_OFF:     ReadData = {{(32-LED_W){1'b0}}, r_led};
        SWITCH_OFF:  ReadData = {{(32-SW_W){1'b0}}, r_sw_sync};
        DIGI_OFF:    ReadData = {{(32-DIGI_W){1'b0}}, r_digi};
        SYSTICK_OFF: ReadData = r_systick;
        default:     ReadData = '0;
      endcase
    end
  end

  assign IRQ  = w_tcon[TCON_IS];
  assign leds = r_led;
  assign digi = r_digi;

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus: register map, timer reload/IRQ priority, sync lag, decode misses, reset.
module tb_periph_bus;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IRQ;
  logic [7:0]  leds;
  logic [7:0]  switch;
  logic [11:0] digi;

  int total = 0;
  int bad   = 0;
  logic [31:0] cyc = 0;

  periph_bus dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .IRQ       (IRQ),
    .leds      (leds),
    .switch    (switch),
    .digi      (digi)
  );

  always #10 clk = ~clk;

  // Reference count of edges since reset release, used as the expected SYSTICK value
  always @(posedge clk) cyc <= reset ? 32'd0 : cyc + 32'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("chk %-14s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0; switch = 8'h00;
    repeat (3) step();
    reset = 1'b0;

    // 1. reset state
    rd_chk("rst_th",   A_TH,   32'h0);
    rd_chk("rst_tl",   A_TL,   32'h0);
    rd_chk("rst_tcon", A_TCON, 32'h0);
    rd_chk("rst_led",  A_LED,  32'h0);
    rd_chk("rst_sw",   A_SW,   32'h0);
    rd_chk("rst_digi", A_DIGI, 32'h0);
    rd_chk("rst_tick", A_TICK, 32'h0);
    chk("rst_irq",  {31'b0, IRQ}, 32'h0);
    chk("rst_leds", {24'b0, leds}, 32'h0);
    chk("rst_digo", {20'b0, digi}, 32'h0);
    repeat (3) step();
    rd_chk("tick_3", A_TICK, 32'd3);

    // 2. reload and interrupt
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd_chk("tl_fffe", A_TL, 32'hFFFF_FFFE);
    step();
    rd_chk("tl_ffff", A_TL, 32'hFFFF_FFFF);
    chk("irq_pre", {31'b0, IRQ}, 32'h0);
    step();
    rd_chk("tl_reload", A_TL, 32'hFFFF_FFFC);
    chk("irq_set", {31'b0, IRQ}, 32'h1);
    rd_chk("tcon_111", A_TCON, 32'h7);
    wr(A_TCON, 32'h3);
    chk("irq_clr", {31'b0, IRQ}, 32'h0);
    rd_chk("tl_fffd", A_TL, 32'hFFFF_FFFD);
    step();
    rd_chk("tl_fffe2", A_TL, 32'hFFFF_FFFE);

    // 3. TCON write on the overflow edge wins
    step();
    rd_chk("tl_ffff2", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    rd_chk("tcon_001", A_TCON, 32'h1);
    chk("irq_lost", {31'b0, IRQ}, 32'h0);
    rd_chk("tl_rel2", A_TL, 32'hFFFF_FFFC);
    step();
    rd_chk("tl_fffd2", A_TL, 32'hFFFF_FFFD);
    chk("irq_lost2", {31'b0, IRQ}, 32'h0);
    wr(A_TCON, 32'h0);
    step();
    rd_chk("tl_hold", A_TL, 32'hFFFF_FFFE);

    // 4. LED / DIGI / SYSTICK
    wr(A_LED, 32'h0000_01A5);
    chk("leds_a5", {24'b0, leds}, 32'hA5);
    rd_chk("rd_led", A_LED, 32'hA5);
    wr(A_DIGI, 32'h0000_F3C0);
    chk("digi_3c0", {20'b0, digi}, 32'h3C0);
    rd_chk("rd_digi", A_DIGI, 32'h3C0);
    wr(A_TICK, 32'h0);
    rd_chk("tick_nowr", A_TICK, cyc);
    Address = A_LED; WriteData = 32'h3C; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    chk("rdwr_pre", ReadData, 32'hA5);
    step();
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("rdwr_post", {24'b0, leds}, 32'h3C);

    // 5. switch sync lag and decode misses
    switch = 8'h5A;
    rd_chk("sw_lag0", A_SW, 32'h0);
    step();
    rd_chk("sw_lag1", A_SW, 32'h0);
    step();
    rd_chk("sw_5a", A_SW, 32'h5A);
    rd_chk("miss_20", 32'h4000_0020, 32'h0);
    rd_chk("unmap_1c", 32'h4000_001C, 32'h0);
    rd_chk("byte_ofs", 32'h4000_000D, 32'h3C);
    Address = A_TL; MemRead = 1'b0;
    #1;
    chk("no_rd", ReadData, 32'h0);
    wr(32'h4000_002C, 32'hFF);
    chk("miss_wr", {24'b0, leds}, 32'h3C);

    // 6. reset mid-count
    wr(A_TL, 32'h1234);
    wr(A_TCON, 32'h5);
    chk("irq_sw", {31'b0, IRQ}, 32'h1);
    rd_chk("tl_1234", A_TL, 32'h1234);
    step();
    rd_chk("tl_1235", A_TL, 32'h1235);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_chk("mr_tl", A_TL, 32'h0);
    rd_chk("mr_tcon", A_TCON, 32'h0);
    chk("mr_irq",  {31'b0, IRQ}, 32'h0);
    chk("mr_leds", {24'b0, leds}, 32'h0);
    chk("mr_digi", {20'b0, digi}, 32'h0);
    repeat (2) step();
    rd_chk("mr_hold", A_TL, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/periph_bus.md
Name: periph_bus

Overview:
- Memory-mapped peripheral responder for the single-cycle MIPS core.
- It is the slave end of the MemRead/MemWrite/Address/WriteData/ReadData interface that the control unit drives, for accesses in the peripheral window.
- Contains an interval timer with interrupt, LED and 7-segment output registers, a synchronised switch input, and a free-running system tick counter.
- Sits beside data memory; the top-level read mux selects its ReadData when the address falls in the window.

Parameters:
- BASE_ADDR, 32'h4000_0000, word-aligned base of the peripheral window.
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  read strobe from the core.
- MemWrite  input  1  write strobe from the core.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data (rt).
- ReadData  output  32  load data; combinational.
- IRQ  output  1  timer interrupt request; level, equals TCON[2].
- leds  output  LED_W  LED register.
- switch  input  SW_W  asynchronous board switches.
- digi  output  12  7-segment register, {anode[3:0], seg[7:0]}.

Behaviour:
- Register map, offsets from BASE_ADDR; Address[1:0] is ignored:
  - 0x00 TH (rw, 32)
  - 0x04 TL (rw, 32)
  - 0x08 TCON (rw, 3): bit0 enable, bit1 irq_en, bit2 irq_status
  - 0x0C LED (rw, LED_W)
  - 0x10 SWITCH (ro)
  - 0x14 DIGI (rw, 12)
  - 0x18 SYSTICK (ro, 32)
- Hit: Address[31:5] equals BASE_ADDR[31:5] and the offset is one of the seven above. Misses and unmapped offsets are ignored.
- Reset (synchronous, checked first): TH, TL, TCON, LED, DIGI, SYSTICK and both switch sync stages go to 0. Therefore leds=0, digi=0, IRQ=0.
- Write: on a clock edge with MemWrite=1 and a hit, the target register takes WriteData truncated to its width; the update is visible the next cycle. Writes to SWITCH and SYSTICK are ignored.
- Read: ReadData is combinational, zero-extended, same cycle, so lw completes in one cycle. ReadData=0 when MemRead=0, on a miss, or on an unmapped offset.
- MemRead and MemWrite both high: the write occurs at the edge; ReadData shows the pre-edge value.
- Timer, each cycle with TCON[0]=1:
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - TL == 32'hFFFF_FFFF: TL <= TH (reload); if TCON[1]=1, TCON[2] <= 1.
  - TCON[0]=0: TL holds.
- Priority: a CPU write to TL or TCON in the same cycle as a timer update wins over that update, including over the overflow set of TCON[2]. The interrupt is lost in that case, which is intended so software can clear IRQ deterministically.
- IRQ stays high until software writes TCON with bit2=0. Clearing TCON[1] does not clear bit2.
- SYSTICK increments every cycle and wraps 32'hFFFF_FFFF to 0. It is unaffected by MemWrite.
- SWITCH passes through a 2-flop synchroniser. The read value lags a switch change by 2 clock edges.
- Reset asserted mid-count clears everything at that edge. The timer resumes only after software sets TCON[0].

Decomposition:
- Shared package: offset constants (TH_OFF … SYSTICK_OFF) and TCON bit indices (TCON_EN=0, TCON_IE=1, TCON_IS=2).
- One sub-module, periph_timer, holding TH, TL and TCON, the reload/overflow logic and the write-priority logic.
- Address decode, LED/DIGI/SWITCH/SYSTICK and the read mux stay in periph_bus.

Test Plan:
1. Reset, then read all seven offsets -> ReadData=0 for each; IRQ=0, leds=0, digi=0. SYSTICK reads a small nonzero count matching cycles elapsed since reset.
2. Write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3'b011 -> TL reads FFFF_FFFF one cycle later, then FFFF_FFFC; IRQ=1 from the cycle after the overflow edge. Write TCON=3'b011 -> IRQ=0 next cycle while counting continues.
3. Overflow edge coincides with a TCON=3'b001 write -> TCON reads 001, IRQ stays 0, TL reloads to TH.
4. Write LED=32'h0000_01A5 and DIGI=32'h0000_F3C0 -> leds=8'hA5, digi=12'h3C0. A write to 0x18 leaves SYSTICK counting unaffected.
5. Change switch 8'h00 -> 8'h5A -> SWITCH reads 00 for 2 edges, then 5A. Read 0x40000020, and 0x40000004 with MemRead=0 -> ReadData=0.
6. Assert reset mid-count (TL=32'h1234) -> TL=0, TCON=0, IRQ=0 next cycle; TL holds at 0 with no counting.
